// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates ID-stage branch conditions from Zero/Sign flags,
// issues a registered PC redirect with a multi-cycle flush, and keeps statistics.
module branch_resolve_unit #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              BrValid,
    input  logic [2:0]        BrOp,
    input  logic              OpsReady,
    input  logic              Zero,
    input  logic              Sign,
    input  logic [ADDR_W-1:0] BrTarget,
    input  logic [ADDR_W-1:0] RegTarget,
    output logic              BrAccept,
    output logic              Stall,
    output logic              PCSrc,
    output logic [ADDR_W-1:0] NewPC,
    output logic              Flush,
    output logic [CNT_W-1:0]  TakenCount,
    output logic [CNT_W-1:0]  NotTakenCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REDIRECT
    } state_e;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BGTZ = 3'd2,
        OP_BLEZ = 3'd3,
        OP_BLTZ = 3'd4,
        OP_BGEZ = 3'd5,
        OP_J    = 3'd6,
        OP_JR   = 3'd7
    } br_op_e;

    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_e              state_q, state_d;
    logic [2:0]          flush_cnt_q, flush_cnt_d;
    logic                redir_q, redir_d;
    logic [ADDR_W-1:0]   new_pc_q, new_pc_d;
    logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0]    not_taken_cnt_q, not_taken_cnt_d;

    logic                br_taken;
    logic [ADDR_W-1:0]   br_target;
    logic                evaluate;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        br_taken = 1'b0;
        unique case (br_op_e'(BrOp))
            OP_BEQ:  br_taken = Zero;
            OP_BNE:  br_taken = !Zero;
            OP_BGTZ: br_taken = !Sign && !Zero;
            OP_BLEZ: br_taken = Sign || Zero;
            OP_BLTZ: br_taken = Sign;
            OP_BGEZ: br_taken = !Sign;
            OP_J:    br_taken = 1'b1;
            OP_JR:   br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    assign br_target = (br_op_e'(BrOp) == OP_JR) ? RegTarget : BrTarget;
    // The shadow instruction is being squashed during REDIRECT, so requests are ignored there.
    assign evaluate  = (state_q != S_REDIRECT) && BrValid && OpsReady;

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_WAIT: begin
                if (!BrValid) begin
                    state_d = S_IDLE;
                end else if (OpsReady) begin
                    state_d = br_taken ? S_REDIRECT : S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_REDIRECT: begin
                if (flush_cnt_q == 3'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BrAccept = evaluate;
        Stall    = (state_q != S_REDIRECT) && BrValid && !OpsReady;
    end

    always_comb begin
        flush_cnt_d     = flush_cnt_q;
        redir_d         = redir_q;
        new_pc_d        = new_pc_q;
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;

        if (state_q == S_REDIRECT) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q == 3'd1) begin
                redir_d = 1'b0;
            end
        end else if (evaluate) begin
            if (br_taken) begin
                new_pc_d    = br_target;
                redir_d     = 1'b1;
                flush_cnt_d = FLUSH_INIT;
                if (taken_cnt_q != CNT_MAX) begin
                    taken_cnt_d = taken_cnt_q + CNT_W'(1);
                end
            end else if (not_taken_cnt_q != CNT_MAX) begin
                not_taken_cnt_d = not_taken_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flush_cnt_q     <= '0;
            redir_q         <= 1'b0;
            new_pc_q        <= '0;
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else begin
            flush_cnt_q     <= flush_cnt_d;
            redir_q         <= redir_d;
            new_pc_q        <= new_pc_d;
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
        end
    end

    // PCSrc and Flush share one flop so they can never disagree.
    assign PCSrc         = redir_q;
    assign Flush         = redir_q;
    assign NewPC         = new_pc_q;
    assign TakenCount    = taken_cnt_q;
    assign NotTakenCount = not_taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: two instances (default params, and FLUSH_CYCLES=3/CNT_W=2)
// share directed stimulus and are checked every cycle against an abstract model.
module tb_branch_resolve_unit;

    localparam int AW = 32;
    localparam int FLUSH_N [2] = '{1, 3};
    localparam int CMAX    [2] = '{65535, 3};

    logic          Clk;
    logic          Reset;
    logic          BrValid;
    logic [2:0]    BrOp;
    logic          OpsReady;
    logic          Zero;
    logic          Sign;
    logic [AW-1:0] BrTarget;
    logic [AW-1:0] RegTarget;

    logic          acc   [2];
    logic          stall [2];
    logic          pcsrc [2];
    logic          flush [2];
    logic [AW-1:0] newpc [2];
    logic [15:0]   tc0, ntc0;
    logic [1:0]    tc1, ntc1;

    int tests = 0;
    int fails = 0;

    branch_resolve_unit #(.ADDR_W(AW), .FLUSH_CYCLES(1), .CNT_W(16)) dut0 (
        .Clk(Clk), .Reset(Reset), .BrValid(BrValid), .BrOp(BrOp), .OpsReady(OpsReady),
        .Zero(Zero), .Sign(Sign), .BrTarget(BrTarget), .RegTarget(RegTarget),
        .BrAccept(acc[0]), .Stall(stall[0]), .PCSrc(pcsrc[0]), .NewPC(newpc[0]),
        .Flush(flush[0]), .TakenCount(tc0), .NotTakenCount(ntc0)
    );

    branch_resolve_unit #(.ADDR_W(AW), .FLUSH_CYCLES(3), .CNT_W(2)) dut1 (
        .Clk(Clk), .Reset(Reset), .BrValid(BrValid), .BrOp(BrOp), .OpsReady(OpsReady),
        .Zero(Zero), .Sign(Sign), .BrTarget(BrTarget), .RegTarget(RegTarget),
        .BrAccept(acc[1]), .Stall(stall[1]), .PCSrc(pcsrc[1]), .NewPC(newpc[1]),
        .Flush(flush[1]), .TakenCount(tc1), .NotTakenCount(ntc1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a unit is either busy redirecting (cycles left) or free to resolve a branch.
    int          m_busy  [2];
    logic [AW-1:0] m_newpc [2];
    int          m_tc    [2];
    int          m_ntc   [2];

    function automatic logic model_taken(input logic [2:0] op, input logic z, input logic s);
        case (op)
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return !s && !z;
            3'd3:    return s || z;
            3'd4:    return s;
            3'd5:    return !s;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k]  <= 0;
                m_newpc[k] <= '0;
                m_tc[k]    <= 0;
                m_ntc[k]   <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_busy[k] > 0) begin
                    m_busy[k] <= m_busy[k] - 1;
                end else if (BrValid && OpsReady) begin
                    if (model_taken(BrOp, Zero, Sign)) begin
                        m_busy[k]  <= FLUSH_N[k];
                        m_newpc[k] <= (BrOp == 3'd7) ? RegTarget : BrTarget;
                        m_tc[k]    <= (m_tc[k] < CMAX[k]) ? m_tc[k] + 1 : m_tc[k];
                    end else begin
                        m_ntc[k]   <= (m_ntc[k] < CMAX[k]) ? m_ntc[k] + 1 : m_ntc[k];
                    end
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            for (int k = 0; k < 2; k++) begin
                logic free;
                free = (m_busy[k] == 0);
                check($sformatf("u%0d_accept", k), 64'(acc[k]),   64'(free && BrValid && OpsReady));
                check($sformatf("u%0d_stall",  k), 64'(stall[k]), 64'(free && BrValid && !OpsReady));
                check($sformatf("u%0d_pcsrc",  k), 64'(pcsrc[k]), 64'(!free));
                check($sformatf("u%0d_flush",  k), 64'(flush[k]), 64'(!free));
                check($sformatf("u%0d_newpc",  k), 64'(newpc[k]), 64'(m_newpc[k]));
            end
            check("u0_taken_cnt", 64'(tc0),  64'(m_tc[0]));
            check("u0_nt_cnt",    64'(ntc0), 64'(m_ntc[0]));
            check("u1_taken_cnt", 64'(tc1),  64'(m_tc[1]));
            check("u1_nt_cnt",    64'(ntc1), 64'(m_ntc[1]));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        BrValid  = 1'b0;
        OpsReady = 1'b0;
        repeat (n) tick();
    endtask

    // Presents one branch, holds OpsReady low for stall_n cycles, then resolves it.
    // Returns one time unit after the accepting edge with BrValid dropped.
    task automatic do_branch(input logic [2:0] op, input logic z, input logic s,
                             input logic [AW-1:0] tgt, input logic [AW-1:0] rtgt,
                             input int stall_n);
        BrValid   = 1'b1;
        BrOp      = op;
        Zero      = z;
        Sign      = s;
        BrTarget  = tgt;
        RegTarget = rtgt;
        OpsReady  = 1'b0;
        for (int i = 0; i < stall_n; i++) begin
            #3;
            check("lit_stall_high", 64'(stall[0]), 64'd1);
            check("lit_stall_noacc", 64'(acc[0]), 64'd0);
            tick();
        end
        OpsReady = 1'b1;
        #3;
        check("lit_accept", 64'(acc[0]), 64'd1);
        check("lit_accept_nostall", 64'(stall[0]), 64'd0);
        tick();
        BrValid  = 1'b0;
        OpsReady = 1'b0;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b1; BrValid = 1'b0; BrOp = '0; OpsReady = 1'b0;
        Zero = 1'b0; Sign = 1'b0; BrTarget = '0; RegTarget = '0;
        apply_reset();
        check("lit_reset_pcsrc", 64'(pcsrc[0]), 64'd0);
        check("lit_reset_taken", 64'(tc0), 64'd0);

        // Reset during the second REDIRECT cycle of the 3-cycle unit.
        do_branch(3'd6, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 0);
        check("lit_redirect_c1", 64'(pcsrc[1]), 64'd1);
        tick();
        check("lit_redirect_c2", 64'(flush[1]), 64'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("lit_async_pcsrc", 64'(pcsrc[1]), 64'd0);
        check("lit_async_flush", 64'(flush[1]), 64'd0);
        check("lit_async_taken", 64'(tc1), 64'd0);
        check("lit_async_taken0", 64'(tc0), 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        idle(2);

        // BEQ taken: one-cycle redirect on the default unit.
        do_branch(3'd0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0);
        check("lit_beq_pcsrc", 64'(pcsrc[0]), 64'd1);
        check("lit_beq_newpc", 64'(newpc[0]), 64'h40);
        check("lit_beq_flush", 64'(flush[0]), 64'd1);
        check("lit_beq_taken", 64'(tc0), 64'd1);
        tick();
        check("lit_beq_flush_end", 64'(flush[0]), 64'd0);
        idle(3);

        // BNE with Zero=1: not taken, no redirect.
        do_branch(3'd1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 0);
        check("lit_bne_pcsrc", 64'(pcsrc[0]), 64'd0);
        check("lit_bne_nt", 64'(ntc0), 64'd1);
        check("lit_bne_newpc_hold", 64'(newpc[0]), 64'h40);
        idle(4);

        do_branch(3'd2, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 0);
        idle(4);
        do_branch(3'd3, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 0);
        idle(4);
        do_branch(3'd4, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 0);
        idle(4);
        check("lit_mix_taken", 64'(tc0), 64'd3);
        check("lit_mix_nt", 64'(ntc0), 64'd2);
        check("lit_mix_newpc", 64'(newpc[0]), 64'h400);

        // BGEZ with Sign=1 is not taken; BGEZ with Sign=0 is taken.
        do_branch(3'd5, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 0);
        idle(4);
        do_branch(3'd5, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 0);
        idle(4);

        // JR with three stall cycles; target comes from RegTarget.
        do_branch(3'd7, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 3);
        check("lit_jr_newpc", 64'(newpc[0]), 64'h1234);
        idle(4);

        // J on the 3-cycle unit while BrValid re-asserts during REDIRECT.
        BrValid = 1'b1; BrOp = 3'd6; OpsReady = 1'b1; BrTarget = 32'h0000_0700;
        tick();
        BrOp = 3'd0; Zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("lit_j3_flush", 64'(flush[1]), 64'd1);
            check("lit_j3_noacc", 64'(acc[1]), 64'd0);
            tick();
        end
        BrValid = 1'b0; OpsReady = 1'b0;
        #3;
        check("lit_j3_flush_end", 64'(flush[1]), 64'd0);
        check("lit_j3_newpc", 64'(newpc[1]), 64'h700);
        idle(4);

        // Saturation of the 2-bit counter after five taken jumps.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_branch(3'd6, 1'b0, 1'b0, 32'h0000_1000 + 32'(i), 32'h0, 0);
            idle(4);
        end
        check("lit_sat_taken1", 64'(tc1), 64'd3);
        check("lit_sat_taken0", 64'(tc0), 64'd5);
        check("lit_sat_newpc", 64'(newpc[1]), 64'h1004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
